rv_write_queue: RTL
===================

// Module: rv_write_queue
// PURPOSE
//  Parametrised writeback stage with an in-order retire queue and decoupled load-return handshake.
//  Accepts completed instructions from the memory stage via valid/ready.
//  Load data arrives later, in order, on a separate response channel.
//  Results retire strictly in program order, one register-file write per cycle.
//  Sits between the memory stage and the register file; replaces the fixed-latency writeback register.
// PARAMETERS
//  XLEN   32  datapath width; legal values are 32 and 64 (64 adds LD/LWU and uses addr[2:0])
//  DEPTH  4   retire-queue entries; power of two, 2..16
// PORTS
//  i_clk           in   1          clock, rising edge
//  i_reset         in   1          asynchronous, active-high reset
//  i_valid         in   1          memory-stage instruction valid
//  o_ready         out  1          queue can accept (registered, = count<DEPTH)
//  i_alu_result    in   XLEN       ALU result; low bits are the load byte offset
//  i_reg_write     in   1          instruction writes rd
//  i_rd            in   5          destination register
//  i_res_src       in   2          result select: ALU / MEMORY / PC_P4
//  i_pc_p4         in   XLEN-2     PC+4 [XLEN-1:2]
//  i_funct3        in   3          load size/sign
//  i_mem_rvalid    in   1          load response valid (in order, always accepted)
//  i_mem_rdata     in   XLEN       raw aligned load word
//  o_data          out  XLEN       writeback data
//  o_rd            out  5          writeback register
//  o_reg_write     out  1          register-file write strobe
//  o_count         out  $clog2(DEPTH)+1  occupied entries
//  o_err           out  1          sticky: load response with no pending load
// BEHAVIOUR
//  - Reset (async): all outputs 0, pointers 0, every entry EMPTY, o_ready=1 from first clock after release.
//  - Per-entry state:
//    - EMPTY -> (accept) -> DONE when res_src!=MEMORY.
//    - EMPTY -> (accept) -> WAIT when res_src==MEMORY.
//    - WAIT -> DONE on the response matched to it.
//    - DONE -> EMPTY on retire.
//  - Accept on edge where i_valid && o_ready; the result is computed at accept time:
//    - ALU: i_alu_result.
//    - PC_P4: {i_pc_p4,2'b00}.
//    - res_src 2'b11: 0.
//  - Response pointer advances to the oldest WAIT entry.
//    - On i_mem_rvalid, the entry is aligned via rv_load_align (funct3, offset), then stored and marked DONE.
//    - funct3 000/001/010/100/101: LB/LH/LW/LBU/LHU.
//    - With XLEN=64, 011/110 are LD/LWU; other codes give 0.
//  - Retire: head DONE -> registered o_reg_write=i_reg_write&&(rd!=0), o_rd, o_data on the next edge.
//    - o_reg_write is 0 in cycles without retire; o_data and o_rd hold their last values.
//  - Latency: non-load accepted at edge E, queue empty -> write visible after E+1. Load response at edge R -> visible after R+1.
//  - Younger DONE entries never retire past an older WAIT entry.
//  - Simultaneous accept+retire in one cycle is legal; count unchanged. o_ready does not see the same-cycle retire.
//  - Response with no WAIT entry: data dropped, no state change, o_err set until reset.
//  - Response and accept of a load in the same cycle: the response goes to the older WAIT entry, never the new one.
//  - Pointer wrap modulo DEPTH; full/empty via an extra pointer bit.
// CONFIGURATION
//  RV_WRITE_BYPASS_EN defined:
//    - If the head is WAIT and i_mem_rvalid matches it, aligned data loads the output registers on the same edge R.
//    - Latency is 1 cycle shorter; the entry retires directly and skips DONE.
//  RV_WRITE_BYPASS_EN undefined: the response always passes through DONE (R+1 latency).
// STRUCTURE
//  - Package rv_write_pkg:
//    - res_src_e (ALU=0, MEMORY=1, PC_P4=2).
//    - Load funct3 constants.
//    - entry_state_e (EMPTY/WAIT/DONE).
//    - Entry struct {state, reg_write, rd, funct3, offset, data}.
//  - Sub-module rv_load_align: combinational byte/half/word(/dword) select and sign/zero extension; reused by the load path.
// TESTING
//  1. ALU op, rd=5, i_alu_result=0x0000_1234 -> o_reg_write=1, o_rd=5, o_data=0x0000_1234 two edges after accept.
//  2. LB offset 3, rdata 0x80FF_0000 -> 0xFFFF_FF80. Same with LBU -> 0x0000_0080. LHU offset 2 -> 0x0000_80FF.
//  3. Load rd=1, then ALU rd=2 (0x55), response 5 cycles later -> rd=1 written, then rd=2 on the next cycle; never rd=2 first.
//  4. DEPTH=4: four loads, no responses -> o_ready=0, o_count=4. One response -> retire, o_ready=1 next cycle.
//  5. i_mem_rvalid with an empty queue -> no write, o_err=1 until reset. rd=0 ALU op -> o_reg_write stays 0.
//  6. Reset mid-operation with 3 entries -> all outputs 0, o_count=0.
//     JAL pc_p4=0x40 after reset -> o_data=0x100.
//     Rerun test 3 with RV_WRITE_BYPASS_EN -> rd=1 one cycle earlier.

Source files
------------

// File: rtl/rv_write_pkg.sv
// Shared types for the in-order writeback queue: result selects, load funct3
// codes, per-entry state and the queue entry layout.
package rv_write_pkg;

  localparam int XLEN_MAX = 64;

  typedef enum logic [1:0] {
    RES_ALU    = 2'd0,
    RES_MEMORY = 2'd1,
    RES_PC_P4  = 2'd2
  } res_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2
  } entry_state_e;

  // Data is held at the widest supported XLEN; narrower builds use the low bits.
  typedef struct packed {
    entry_state_e          state;
    logic                  reg_write;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic [2:0]            offset;
    logic [XLEN_MAX-1:0]   data;
  } entry_t;

endpackage

// File: rtl/rv_write_queue_align.sv
// rv_load_align: selects the addressed byte/half/word(/dword) from a raw
// aligned load word and applies sign or zero extension.
module rv_load_align
  import rv_write_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  // Offset bit 2 is always zero on 32-bit builds, so one shifter serves both widths.
  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = XLEN'($signed(shifted[7:0]));
      F3_LH:   data = XLEN'($signed(shifted[15:0]));
      F3_LW:   data = XLEN'($signed(shifted[31:0]));
      F3_LBU:  data = XLEN'(shifted[7:0]);
      F3_LHU:  data = XLEN'(shifted[15:0]);
      F3_LD:   if (XLEN == 64) data = shifted;
      F3_LWU:  if (XLEN == 64) data = XLEN'(shifted[31:0]);
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/rv_write_queue.sv
// Writeback stage with an in-order retire queue and decoupled load returns.
// Define RV_WRITE_BYPASS_EN to retire a load at the head on its response edge.
module rv_write_queue
  import rv_write_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [XLEN-1:0]            i_alu_result,
  input  logic                       i_reg_write,
  input  logic [4:0]                 i_rd,
  input  logic [1:0]                 i_res_src,
  input  logic [XLEN-3:0]            i_pc_p4,
  input  logic [2:0]                 i_funct3,
  input  logic                       i_mem_rvalid,
  input  logic [XLEN-1:0]            i_mem_rdata,
  output logic [XLEN-1:0]            o_data,
  output logic [4:0]                 o_rd,
  output logic                       o_reg_write,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          q [DEPTH];
  entry_t          new_entry;
  logic [PW:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]   wr_idx, head_idx, resp_idx;
  logic [CW-1:0]   count, count_next;
  logic            ready_q, err_q;
  logic            accept, resp_hit, resp_match, bypass, retire;
  logic [XLEN-1:0] aligned, accept_data;

  assign wr_idx     = wr_ptr[PW-1:0];
  assign head_idx   = rd_ptr[PW-1:0];
  assign count      = wr_ptr - rd_ptr;
  assign accept     = i_valid && ready_q;
  assign resp_match = i_mem_rvalid && resp_hit;

  // Responses arrive in order, so they always belong to the oldest waiting load.
  always_comb begin
    resp_hit = 1'b0;
    resp_idx = head_idx;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q[head_idx + PW'(i)].state == ST_WAIT) begin
        resp_hit = 1'b1;
        resp_idx = head_idx + PW'(i);
      end
    end
  end

  rv_load_align #(.XLEN(XLEN)) u_align (
    .funct3 (q[resp_idx].funct3),
    .offset (q[resp_idx].offset),
    .rdata  (i_mem_rdata),
    .data   (aligned)
  );

`ifdef RV_WRITE_BYPASS_EN
  assign bypass = resp_match && (resp_idx == head_idx);
`else
  assign bypass = 1'b0;
`endif

  assign retire     = (q[head_idx].state == ST_DONE) || bypass;
  assign count_next = count + CW'(accept) - CW'(retire);

  always_comb begin
    accept_data = '0;
    case (i_res_src)
      RES_ALU:   accept_data = i_alu_result;
      RES_PC_P4: accept_data = {i_pc_p4, 2'b00};
      default:   accept_data = '0;
    endcase
    new_entry           = '0;
    new_entry.state     = (i_res_src == RES_MEMORY) ? ST_WAIT : ST_DONE;
    new_entry.reg_write = i_reg_write;
    new_entry.rd        = i_rd;
    new_entry.funct3    = i_funct3;
    new_entry.offset    = (XLEN == 64) ? i_alu_result[2:0] : {1'b0, i_alu_result[1:0]};
    new_entry.data      = XLEN_MAX'(accept_data);
  end

  // Accept, response and retire always touch distinct slots in the same cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      if (accept) q[wr_idx] <= new_entry;
      if (resp_match && !bypass) begin
        q[resp_idx].state <= ST_DONE;
        q[resp_idx].data  <= XLEN_MAX'(aligned);
      end
      if (retire) q[head_idx].state <= ST_EMPTY;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      o_reg_write <= 1'b0;
      o_rd        <= '0;
      o_data      <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (retire) rd_ptr <= rd_ptr + 1'b1;
      ready_q     <= (count_next != CW'(DEPTH));
      if (i_mem_rvalid && !resp_hit) err_q <= 1'b1;
      o_reg_write <= retire && q[head_idx].reg_write && (q[head_idx].rd != 5'd0);
      if (retire) begin
        o_rd   <= q[head_idx].rd;
        o_data <= bypass ? aligned : q[head_idx].data[XLEN-1:0];
      end
    end
  end

  assign o_ready = ready_q;
  assign o_count = count;
  assign o_err   = err_q;

endmodule
